// File: rtl/prog_interval_timer.sv
// -----------------------------------------------------------------------------
// prog_interval_timer
//
// Programmable interval timer. Counts clk cycles up to a run-time loadable
// period and emits a one-cycle tick at every terminal count, either
// periodically or once (one-shot). Start/stop pulses and an enable level give
// run, halt and pause control. Intended for display refresh, blink and
// debounce logic that needs intervals other than the classic 1 s rollover.
//
// Parameters
//   WIDTH       counter / period width in bits
//   DEF_PERIOD  period loaded at reset; must fit in WIDTH bits and be nonzero
//   AUTO_START  1: RUNNING after reset, 0: IDLE after reset
//
// Ports
//   clk        in   1      system clock, rising edge
//   Reset      in   1      asynchronous, active-high reset
//   start      in   1      pulse: clear count and enter RUNNING
//   stop       in   1      pulse: clear count and enter IDLE (wins over start)
//   en         in   1      level: 1 counts, 0 pauses (holds count) while RUNNING
//   oneshot    in   1      level: 1 one-shot, 0 periodic; sampled at terminal
//   period_wr  in   1      pulse: load period_in into the period register
//   period_in  in   WIDTH  new period in clk cycles; 0 is ignored
//   count      out  WIDTH  current count, 0 .. period-1
//   tick       out  1      registered one-cycle pulse on terminal count
//   running    out  1      state == RUNNING
//   done       out  1      state == DONE (one-shot expired)
// -----------------------------------------------------------------------------
module prog_interval_timer #(
  parameter int WIDTH      = 26,
  parameter int DEF_PERIOD = 50000000,
  parameter bit AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             oneshot,
  input  logic             period_wr,
  input  logic [WIDTH-1:0] period_in,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? RUNNING : IDLE;

  state_t           state;
  logic [WIDTH-1:0] period;
  logic             terminal;

  // Terminal uses ">=" rather than "==" so that shrinking the period below the
  // current count ends the interval on the next counting cycle instead of
  // letting the counter run on up to 2^WIDTH and wrap. The compare always sees
  // the period register as it was before this edge, so a period_wr landing on
  // a terminal edge only affects the following interval.
  assign terminal = (count >= period - WIDTH'(1));

  assign running = (state == RUNNING);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the values from before the edge; blocking assignments here would
  // let later statements see half-updated state and change the priority order.
  // The period register is reset along with everything else, so a Reset
  // always returns the timer to DEF_PERIOD.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state  <= RESET_STATE;
      count  <= '0;
      tick   <= 1'b0;
      done   <= 1'b0;
      period <= WIDTH'(DEF_PERIOD);
    end else begin
      // tick is a pulse: low unless this edge is a terminal count.
      tick <= 1'b0;

      // Period load is independent of the control FSM; zero would make the
      // terminal compare underflow, so it is discarded.
      if (period_wr && (period_in != '0)) begin
        period <= period_in;
      end

      // Priority: stop > start > terminal count > increment.
      if (stop) begin
        state <= IDLE;
        count <= '0;
        done  <= 1'b0;
      end else if (start) begin
        state <= RUNNING;
        count <= '0;
        done  <= 1'b0;
      end else if ((state == RUNNING) && en) begin
        if (terminal) begin
          count <= '0;
          tick  <= 1'b1;
          if (oneshot) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
      // Paused (RUNNING, en=0) holds count; IDLE and DONE hold count at 0,
      // which it already is because every path into them clears it.
    end
  end

endmodule
